// File: rtl/gate_pkg.sv
// Shared types for the gate array: function-select encoding, self-test FSM
// states, and the reference reduction used to grade the datapath.
package gate_pkg;

  typedef enum logic [2:0] {
    MODE_OR   = 3'd0,
    MODE_AND  = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NOR  = 3'd3,
    MODE_NAND = 3'd4,
    MODE_XNOR = 3'd5
  } mode_e;

  localparam int unsigned MODE_LAST = 5;

  typedef enum logic [1:0] {
    BIST_IDLE,
    BIST_RUN,
    BIST_CHECK,
    BIST_DONE
  } bist_state_e;

  // Reference reduction over the low n bits of a column; written as a loop so
  // it shares no structure with the operator-based datapath it grades.
  function automatic logic gate_golden(input logic [2:0] mode,
                                       input logic [7:0] bits,
                                       input int unsigned n);
    logic r_or, r_and, r_xor;
    r_or  = 1'b0;
    r_and = 1'b1;
    r_xor = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (k < n) begin
        r_or  = r_or | bits[k];
        r_and = r_and & bits[k];
        r_xor = r_xor ^ bits[k];
      end
    end
    case (mode)
      MODE_OR:   return r_or;
      MODE_AND:  return r_and;
      MODE_XOR:  return r_xor;
      MODE_NOR:  return ~r_or;
      MODE_NAND: return ~r_and;
      MODE_XNOR: return ~r_xor;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_reduce.sv
// One bit column of the gate array: reduces NUM_IN operand bits under the
// selected mode. Illegal modes yield 0.
module gate_reduce
  import gate_pkg::*;
#(
  parameter int NUM_IN = 2
) (
  input  logic [NUM_IN-1:0] col_i,
  input  logic [2:0]        mode_i,
  output logic              y_o
);

  always_comb begin
    y_o = 1'b0;
    case (mode_i)
      MODE_OR:   y_o = |col_i;
      MODE_AND:  y_o = &col_i;
      MODE_XOR:  y_o = ^col_i;
      MODE_NOR:  y_o = ~|col_i;
      MODE_NAND: y_o = ~&col_i;
      MODE_XNOR: y_o = ~^col_i;
      default:   y_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_array_reg.sv
// Registered multi-mode gate array with a valid/ready output stage.
// Define GATE_SELFTEST_EN to build the exhaustive self-test and bist_* ports.
module gate_array_reg
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_mode,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
`ifdef GATE_SELFTEST_EN
  ,
  input  logic                    bist_start,
  output logic                    bist_busy,
  output logic                    bist_done,
  output logic                    bist_pass
`endif
);

  logic                    busy;
  logic                    bist_kick;
  logic                    bist_load;
  logic [2:0]              dp_mode;
  logic [NUM_IN*WIDTH-1:0] dp_data;
  logic [WIDTH-1:0]        red;

  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    out_err_q, out_err_d;
  logic                    accept;

`ifdef GATE_SELFTEST_EN
  bist_state_e       state_q;
  logic [NUM_IN-1:0] pat_q;
  logic [2:0]        bmode_q;
  logic              exp_q;
  logic              cmp_q;
  logic              acc_q;
  logic              busy_q, done_q, pass_q;
  logic              bist_mis;
  logic              bist_last;

  assign busy      = busy_q;
  assign bist_kick = (state_q == BIST_IDLE) && bist_start;
  assign bist_load = (state_q == BIST_RUN);
  assign bist_busy = busy_q;
  assign bist_done = done_q;
  assign bist_pass = pass_q;
  assign bist_mis  = (out_data_q != {WIDTH{exp_q}}) || out_err_q;
  assign bist_last = (pat_q == {NUM_IN{1'b1}}) && (bmode_q == 3'(MODE_LAST));

  // While busy the datapath sees the sweep vector: operand k is pattern bit k
  // replicated across its width.
  always_comb begin
    dp_mode = in_mode;
    dp_data = in_data;
    if (busy_q) begin
      dp_mode = bmode_q;
      for (int k = 0; k < NUM_IN; k++) dp_data[k*WIDTH +: WIDTH] = {WIDTH{pat_q[k]}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BIST_IDLE;
      pat_q   <= '0;
      bmode_q <= '0;
      exp_q   <= 1'b0;
      cmp_q   <= 1'b0;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        BIST_IDLE: begin
          if (bist_start) begin
            state_q <= BIST_RUN;
            pat_q   <= '0;
            bmode_q <= '0;
            cmp_q   <= 1'b0;
            acc_q   <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        BIST_RUN: begin
          // The register now holds the previous vector's result; grade it
          // while the current vector is being captured.
          if (cmp_q && bist_mis) acc_q <= 1'b0;
          exp_q <= gate_golden(bmode_q, 8'(pat_q), unsigned'(NUM_IN));
          cmp_q <= 1'b1;
          if (pat_q == {NUM_IN{1'b1}}) begin
            pat_q   <= '0;
            bmode_q <= bmode_q + 3'd1;
          end else begin
            pat_q <= pat_q + 1'b1;
          end
          if (bist_last) state_q <= BIST_CHECK;
        end
        BIST_CHECK: begin
          if (cmp_q && bist_mis) acc_q <= 1'b0;
          cmp_q   <= 1'b0;
          state_q <= BIST_DONE;
        end
        BIST_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= acc_q;
          state_q <= BIST_IDLE;
        end
        default: state_q <= BIST_IDLE;
      endcase
    end
  end
`else
  assign busy      = 1'b0;
  assign bist_kick = 1'b0;
  assign bist_load = 1'b0;
  assign dp_mode   = in_mode;
  assign dp_data   = in_data;
`endif

  for (genvar b = 0; b < WIDTH; b++) begin : g_col
    logic [NUM_IN-1:0] col;
    always_comb begin
      col = '0;
      for (int k = 0; k < NUM_IN; k++) col[k] = dp_data[k*WIDTH + b];
    end
    gate_reduce #(.NUM_IN(NUM_IN)) u_red (
      .col_i  (col),
      .mode_i (dp_mode),
      .y_o    (red[b])
    );
  end

  assign in_ready  = !busy && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q && !busy;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

  // Output stage: reload on accept (or sweep vector), drain on out_ready;
  // starting the self-test drops whatever was held.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (accept || bist_load) begin
      out_data_d  = red;
      out_err_d   = (dp_mode > 3'(MODE_LAST));
      out_valid_d = accept;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (bist_kick) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_gate_array_reg.sv
// Scoreboard bench for gate_array_reg: one WIDTH=8/NUM_IN=2 instance and one
// WIDTH=8/NUM_IN=3 instance, directed vectors with hand-computed results.
module tb_gate_array_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_mode;
  logic [15:0] in_data;
  logic [7:0]  out_data;

  logic        in_valid3, in_ready3, out_valid3, out_ready3, out_err3;
  logic [2:0]  in_mode3;
  logic [23:0] in_data3;
  logic [7:0]  out_data3;

`ifdef GATE_SELFTEST_EN
  logic bist_start, bist_busy, bist_done, bist_pass;
  logic bist_start3, bist_busy3, bist_done3, bist_pass3;
`endif

  gate_array_reg #(.WIDTH(8), .NUM_IN(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
`ifdef GATE_SELFTEST_EN
    , .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass)
`endif
  );

  gate_array_reg #(.WIDTH(8), .NUM_IN(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_mode(in_mode3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_err(out_err3)
`ifdef GATE_SELFTEST_EN
    , .bist_start(bist_start3), .bist_busy(bist_busy3), .bist_done(bist_done3), .bist_pass(bist_pass3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] sb[$];
  logic [8:0] sb3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: every handshake on an output pops the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", out_data);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("beat_data", 32'(out_data), 32'(e[7:0]));
        chk("beat_err", 32'(out_err), 32'(e[8]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid3 && out_ready3) begin
      if (sb3.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat3: got 0x%0h, expected no beat", out_data3);
      end else begin
        logic [8:0] e;
        e = sb3.pop_front();
        chk("beat3_data", 32'(out_data3), 32'(e[7:0]));
        chk("beat3_err", 32'(out_err3), 32'(e[8]));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] m, input logic [15:0] d,
                      input logic [7:0] ed, input logic ee);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b, expected 1", in_ready);
    end else begin
      sb.push_back({ee, ed});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send3(input logic [2:0] m, input logic [23:0] d,
                       input logic [7:0] ed, input logic ee);
    in_valid3 = 1'b1;
    in_mode3  = m;
    in_data3  = d;
    @(negedge clk);
    if (!in_ready3) begin
      n_tests++;
      n_fail++;
      $display("FAIL send3_ready: in_ready=%0b, expected 1", in_ready3);
    end else begin
      sb3.push_back({ee, ed});
    end
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    in_valid = 1'b0; in_mode = '0; in_data = '0; out_ready = 1'b1;
    in_valid3 = 1'b0; in_mode3 = '0; in_data3 = '0; out_ready3 = 1'b1;
`ifdef GATE_SELFTEST_EN
    bist_start = 1'b0;
    bist_start3 = 1'b0;
`endif
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
`ifdef GATE_SELFTEST_EN
    chk("rst_bist_busy", 32'(bist_busy), 0);
    chk("rst_bist_done", 32'(bist_done), 0);
    chk("rst_bist_pass", 32'(bist_pass), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic modes at full throughput
    send(3'd0, {8'hF0, 8'h0F}, 8'hFF, 1'b0);
    send(3'd5, {8'hAA, 8'hAA}, 8'hFF, 1'b0);
    send(3'd2, {8'hAA, 8'hAA}, 8'h00, 1'b0);
    send(3'd3, {8'h30, 8'h0F}, 8'hC0, 1'b0);
    send(3'd4, {8'hFF, 8'h0F}, 8'hF0, 1'b0);

    // Backpressure: A held, B stalled, then drain-and-load in one cycle
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(3'd1, {8'h0F, 8'h33}, 8'h03, 1'b0);
    in_valid = 1'b1; in_mode = 3'd2; in_data = {8'h0F, 8'h33};
    @(negedge clk);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_hold_valid", 32'(out_valid), 1);
    chk("bp_hold_data", 32'(out_data), 32'h03);
    @(negedge clk);
    chk("bp_stable_data", 32'(out_data), 32'h03);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_high", 32'(in_ready), 1);
    sb.push_back({1'b0, 8'h3C});
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("bp_b_valid", 32'(out_valid), 1);
    chk("bp_b_data", 32'(out_data), 32'h3C);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Illegal modes, each followed by a legal beat that clears the error
    send(3'd6, 16'h1234, 8'h00, 1'b1);
    send(3'd1, {8'hFF, 8'h0F}, 8'h0F, 1'b0);
    send(3'd7, 16'hFFFF, 8'h00, 1'b1);
    send(3'd0, {8'h00, 8'h00}, 8'h00, 1'b0);

    // Asynchronous reset while a result is held
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(3'd0, {8'h00, 8'hA5}, 8'hA5, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_data", 32'(out_data), 0);
    chk("async_rst_err", 32'(out_err), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Three-operand instance
    send3(3'd4, {8'h3C, 8'hF0, 8'hFF}, 8'hCF, 1'b0);
    send3(3'd1, {8'h3C, 8'hF0, 8'hFF}, 8'h30, 1'b0);
    send3(3'd5, {8'h3C, 8'hF0, 8'hFF}, 8'hCC, 1'b0);
    send3(3'd0, {8'h3C, 8'hF0, 8'h00}, 8'hFC, 1'b0);
    send3(3'd6, {8'h3C, 8'hF0, 8'hFF}, 8'h00, 1'b1);

`ifdef GATE_SELFTEST_EN
    // Self-test: clean run then a run with a stuck column
    for (int run = 0; run < 2; run++) begin
      if (run == 1) force dut.g_col[0].u_red.y_o = 1'b0;
      @(posedge clk);
      #1;
      bist_start = 1'b1;
      @(posedge clk);
      #1;
      bist_start = 1'b0;
      chk("bist_busy", 32'(bist_busy), 1);
      chk("bist_in_ready", 32'(in_ready), 0);
      chk("bist_out_valid", 32'(out_valid), 0);
      cyc = 0;
      while (!bist_done && cyc < 200) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      chk("bist_cycles", 32'(cyc), 26);
      chk("bist_pass", 32'(bist_pass), (run == 0) ? 32'd1 : 32'd0);
      chk("bist_busy_end", 32'(bist_busy), 0);
      if (run == 1) release dut.g_col[0].u_red.y_o;
    end
`endif

    cyc = 0;
    while ((sb.size() != 0 || sb3.size() != 0) && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("sb_empty", 32'(sb.size()), 0);
    chk("sb3_empty", 32'(sb3.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_array_reg.md
# gate_array_reg

Parametrised, registered multi-mode logic-gate unit. Applies one of six bitwise reduction functions (OR, AND, XOR, NOR, NAND, XNOR) across NUM_IN operands of WIDTH bits each. It replaces the fixed two-input OR gates with a single configurable stage that has a valid/ready output register. It sits between stimulus sources and downstream consumers in the lab datapath, and carries an optional built-in exhaustive self-test.

## Interface
Parameters:
- WIDTH, 8, bits per operand (1..32)
- NUM_IN, 2, number of operands (2..8)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  unit can accept a beat
- in_mode  in  3  function select, encoded per gate_pkg
- in_data  in  NUM_IN*WIDTH  packed operands; operand k at [k*WIDTH +: WIDTH]
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  registered result
- out_err  out  1  result came from an illegal mode
- bist_start  in  1  (GATE_SELFTEST_EN only) single-cycle pulse to start self-test
- bist_busy  out  1  (GATE_SELFTEST_EN only)
- bist_done  out  1  (GATE_SELFTEST_EN only) sticky until next start
- bist_pass  out  1  (GATE_SELFTEST_EN only) valid when bist_done=1

## Operation
- Modes: 0 OR, 1 AND, 2 XOR, 3 NOR, 4 NAND, 5 XNOR. Each is a per-bit-column reduction over all NUM_IN operands.
- Modes 6 and 7 are illegal: out_data=0, out_err=1.
- in_ready = !out_valid || out_ready. An accept (in_valid && in_ready) loads out_data and out_err and sets out_valid.
- out_valid clears on out_ready when no new accept occurs in the same cycle.
- Simultaneous drain and accept: the register reloads, out_valid stays 1, and no bubble is inserted.
- out_data is stable while out_valid && !out_ready. The consumer sees every accepted beat exactly once, in order.
- Reset values: out_valid=0, out_data=0, out_err=0, bist_busy=0, bist_done=0, bist_pass=0.
- A reset mid-beat discards the held result.

## Timing
- Latency: 1 cycle. A beat accepted at edge n is visible on out_data after edge n.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready is combinational from out_valid and out_ready. There is no path from in_valid to in_ready.

## Configuration
- GATE_SELFTEST_EN defined: bist_* ports and the self-test FSM are built. FSM states:
  - IDLE: bist_start moves to RUN and clears done/pass.
  - RUN: sweeps mode 0..5 × pattern 0..2^NUM_IN−1, one vector per cycle. Bit k of the pattern is replicated across all WIDTH bits of operand k. The datapath output is compared against the golden function one cycle later; any mismatch clears pass.
  - CHECK: compares the final vector.
  - DONE: sets bist_done and returns to IDLE.
- Total run: 6·2^NUM_IN + 2 cycles from bist_start to bist_done.
- While bist_busy: in_ready=0, out_valid is forced 0, and external beats are not accepted. Any held result is dropped at start.
- bist_start is ignored while busy.
- GATE_SELFTEST_EN undefined: no bist_* ports and no FSM. The datapath is identical to the enabled build in functional behaviour.

## Structure
- Package gate_pkg holds:
  - mode enum: MODE_OR..MODE_XNOR, MODE_LAST=5
  - the BIST state enum
  - function gate_golden(mode, bit-vector), used as the self-test reference
- Sub-module gate_reduce: purely combinational, parameter NUM_IN. Maps one bit column plus mode to a result bit and is instantiated WIDTH times via generate.
- gate_array_reg holds the registers, handshake and FSM.

## Test plan
- Reset mid-beat, at WIDTH=8, NUM_IN=2: assert rst with out_valid=1 → out_valid=0, out_data=0x00, out_err=0 immediately, without waiting for clk.
- OR, operands 0x0F and 0xF0 → out_data=0xFF one cycle later. XNOR, operands 0xAA and 0xAA → 0xFF. XOR, operands 0xAA and 0xAA → 0x00.
- NUM_IN=3, NAND, operands 0xFF, 0xF0, 0x3C → out_data=0xCF. AND on the same operands → 0x30.
- Backpressure: hold out_ready=0 and offer beats A then B.
  - A is held and in_ready=0; B is stalled.
  - Raise out_ready for one cycle → A drains and B loads the same cycle. Order is A then B with no loss.
- Illegal mode 6 with any data → out_data=0x00, out_err=1. A following legal beat clears out_err.
- With GATE_SELFTEST_EN, NUM_IN=2, pulse bist_start:
  - bist_busy=1, in_ready=0.
  - bist_done=1 after 26 cycles with bist_pass=1.
  - A forced fault injected into one gate_reduce column gives bist_pass=0.
